// File: rtl/demux1x4_reg_if.sv
// Purpose : handshake bundle for demux1x4_reg, with one input stream and four drained channels.
// Latency : not applicable, since this file only declares the signals.
// Backpressure: in_ready is driven by the demux, and out_ready[i] is driven by each consumer.
// Ports (slave = demux side):
//   in_valid/in_ready/in_data/in_sel  : input word stream and its destination select
//   out_valid[3:0]/out_ready[3:0]     : per-channel drain handshakes
//   out_data0..3                      : channel holding registers
//   dlv_cnt0..3                       : per-channel delivery counters (mod 256)
interface demux1x4_reg_if #(
    parameter int DATA_WDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_WDTH-1:0] in_data;
    logic [1:0]           in_sel;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [DATA_WDTH-1:0] out_data0;
    logic [DATA_WDTH-1:0] out_data1;
    logic [DATA_WDTH-1:0] out_data2;
    logic [DATA_WDTH-1:0] out_data3;
    logic [7:0]           dlv_cnt0;
    logic [7:0]           dlv_cnt1;
    logic [7:0]           dlv_cnt2;
    logic [7:0]           dlv_cnt3;

    // The demux owns in_ready and all channel outputs.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid,
        output out_data0, out_data1, out_data2, out_data3,
        output dlv_cnt0, dlv_cnt1, dlv_cnt2, dlv_cnt3
    );

    // The sender and consumers drive the stream inputs and the drain readies.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid,
        input  out_data0, out_data1, out_data2, out_data3,
        input  dlv_cnt0, dlv_cnt1, dlv_cnt2, dlv_cnt3
    );
endinterface

// File: rtl/demux1x4_reg.sv
// Purpose : registered 1:4 demux that routes each input word by in_sel into one of four single-entry holding registers.
// Latency : a word accepted at edge N shows out_valid[i]=1 in cycle N+1; pass-through reload sustains one word per cycle per channel.
// Backpressure: in_ready depends only on the selected channel, which must be empty or draining this cycle.
// Ports: clk, rst_n (async active-low), bus (demux1x4_reg_if.slave: in_* stream, out_* channels, dlv_cnt*).
module demux1x4_reg #(
    parameter int DATA_WDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1x4_reg_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t          state_q [4];
    chan_state_t          state_d [4];
    logic [DATA_WDTH-1:0] data_q  [4];
    logic [7:0]           cnt_q   [4];

    logic [3:0] valid;
    logic [3:0] acc;
    logic [3:0] dlv;
    logic       in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            valid[i] = (state_q[i] == FULL);
        end
    end

    // A full channel can still take a word when its consumer drains it in the same cycle.
    assign in_ready = !valid[bus.in_sel] || bus.out_ready[bus.in_sel];

    always_comb begin
        acc = 4'b0000;
        dlv = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            acc[i] = bus.in_valid && in_ready && (bus.in_sel == 2'(i));
            // out_ready is ignored on an empty channel.
            dlv[i] = valid[i] && bus.out_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY:   if (acc[i]) state_d[i] = FULL;
                FULL:    if (dlv[i] && !acc[i]) state_d[i] = EMPTY;
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                // The data register is never cleared on drain; it holds the last word.
                if (acc[i]) data_q[i] <= bus.in_data;
                if (dlv[i]) cnt_q[i]  <= cnt_q[i] + 8'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out_data0 = data_q[0];
    assign bus.out_data1 = data_q[1];
    assign bus.out_data2 = data_q[2];
    assign bus.out_data3 = data_q[3];
    assign bus.dlv_cnt0  = cnt_q[0];
    assign bus.dlv_cnt1  = cnt_q[1];
    assign bus.dlv_cnt2  = cnt_q[2];
    assign bus.dlv_cnt3  = cnt_q[3];
endmodule

// File: tb/tb_demux1x4_reg.sv
// Purpose : directed self-checking bench for demux1x4_reg.
// Latency : inputs are driven 1 time unit after each rising edge, and outputs are checked in that same window.
// Backpressure: out_ready patterns are set per scenario in the directed sequences below.
module tb_demux1x4_reg;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    demux1x4_reg_if #(.DATA_WDTH(8)) bus ();

    demux1x4_reg #(.DATA_WDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Single-cycle accept of a word with all consumers stalled; the channel must be able to take it.
    task automatic send(input logic [7:0] d, input logic [1:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        chk({tag, "_cnt0"}, bus.dlv_cnt0, c0);
        chk({tag, "_cnt1"}, bus.dlv_cnt1, c1);
        chk({tag, "_cnt2"}, bus.dlv_cnt2, c2);
        chk({tag, "_cnt3"}, bus.dlv_cnt3, c3);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // ---------------- reset state ----------------
        chk("rst_valid", bus.out_valid, 4'b0000);
        chk("rst_d0", bus.out_data0, 8'h00);
        chk("rst_d1", bus.out_data1, 8'h00);
        chk("rst_d2", bus.out_data2, 8'h00);
        chk("rst_d3", bus.out_data3, 8'h00);
        chk_counts("rst", 8'd0, 8'd0, 8'd0, 8'd0);
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1 chk("rst_in_ready", bus.in_ready, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        // out_ready is set on empty channels and must produce no count.
        bus.out_ready = 4'b1111;
        step(); step(); step();
        bus.out_ready = 4'b0000;
        chk("idle_valid", bus.out_valid, 4'b0000);
        chk_counts("idle", 8'd0, 8'd0, 8'd0, 8'd0);

        // ---------------- basic routing ----------------
        send(8'hA0, 2'd0);
        chk("route_lat1", bus.out_valid, 4'b0001);
        send(8'hA1, 2'd1);
        send(8'hA2, 2'd2);
        send(8'hA3, 2'd3);
        chk("route_valid", bus.out_valid, 4'b1111);
        chk("route_d0", bus.out_data0, 8'hA0);
        chk("route_d1", bus.out_data1, 8'hA1);
        chk("route_d2", bus.out_data2, 8'hA2);
        chk("route_d3", bus.out_data3, 8'hA3);
        bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.in_sel = 2'd2;
        #1 chk("route_full_rdy", bus.in_ready, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("route_noacc_d2", bus.out_data2, 8'hA2);
        chk("route_noacc_valid", bus.out_valid, 4'b1111);
        // Drain all four channels together.
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        chk("drain_valid", bus.out_valid, 4'b0000);
        chk_counts("drain", 8'd1, 8'd1, 8'd1, 8'd1);
        chk("drain_hold_d0", bus.out_data0, 8'hA0);

        // ---------------- backpressure isolation ----------------
        send(8'h11, 2'd1);
        send(8'h55, 2'd3);
        chk("iso_valid", bus.out_valid, 4'b1010);
        chk("iso_d3", bus.out_data3, 8'h55);
        chk("iso_d1", bus.out_data1, 8'h11);
        bus.in_valid = 1'b1; bus.in_data = 8'h22; bus.in_sel = 2'd1;
        #1 chk("iso_stall_rdy", bus.in_ready, 1'b0);
        step(); step();
        chk("iso_stall_rdy2", bus.in_ready, 1'b0);
        chk("iso_stall_d1", bus.out_data1, 8'h11);
        bus.out_ready = 4'b0010;
        #1 chk("iso_release_rdy", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        // The delivery of 0x11 and the reload with 0x22 happen on the same edge.
        chk("iso_reload_d1", bus.out_data1, 8'h22);
        chk("iso_reload_valid", bus.out_valid, 4'b1010);
        chk("iso_reload_cnt1", bus.dlv_cnt1, 8'd2);
        bus.out_ready = 4'b1010;
        step();
        bus.out_ready = 4'b0000;
        chk("iso_drain_valid", bus.out_valid, 4'b0000);
        chk_counts("iso", 8'd1, 8'd3, 8'd1, 8'd2);

        // ---------------- pass-through streaming ----------------
        do_reset();
        bus.out_ready = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'(k);
            #1 chk("pt_rdy", bus.in_ready, 1'b1);
            if (k > 0) begin
                chk("pt_valid", bus.out_valid, 4'b0001);
                chk("pt_order", bus.out_data0, 32'(k - 1));
            end
            step();
        end
        bus.in_valid = 1'b0;
        chk("pt_last", bus.out_data0, 8'h0F);
        chk("pt_cnt15", bus.dlv_cnt0, 8'd15);
        step();
        bus.out_ready = 4'b0000;
        chk("pt_empty", bus.out_valid, 4'b0000);
        chk_counts("pt", 8'd16, 8'd0, 8'd0, 8'd0);

        // ---------------- counter wrap ----------------
        do_reset();
        bus.out_ready = 4'b0100;
        for (int k = 0; k < 257; k++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'(k);
            step();
        end
        bus.in_valid = 1'b0;
        chk("wrap_256", bus.dlv_cnt2, 8'd0);
        step();
        bus.out_ready = 4'b0000;
        chk_counts("wrap", 8'd0, 8'd0, 8'd1, 8'd0);

        // ---------------- async reset mid-stream ----------------
        do_reset();
        send(8'h33, 2'd1);
        bus.out_ready = 4'b0010;
        step();
        bus.out_ready = 4'b0000;
        send(8'h77, 2'd0);
        send(8'h88, 2'd3);
        chk("ar_pre_valid", bus.out_valid, 4'b1001);
        chk("ar_pre_cnt1", bus.dlv_cnt1, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.out_valid, 4'b0000);
        chk("ar_d0", bus.out_data0, 8'h00);
        chk("ar_d3", bus.out_data3, 8'h00);
        chk_counts("ar", 8'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
